// File: rtl/quick_spi_cmd_sequencer.sv
// quick_spi_cmd_sequencer: FIFO-buffered command issuer and read-response capture for quick_spi_hard
// Optional per-transaction watchdog enabled by defining QUICK_SPI_SEQ_TIMEOUT_EN.
module quick_spi_cmd_sequencer #(
  parameter int OUT_WIDTH      = 16,
  parameter int IN_WIDTH       = 8,
  parameter int SLAVES         = 2,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [SLAVES-1:0]    cmd_slave,
  input  logic [OUT_WIDTH-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IN_WIDTH-1:0]  rsp_data,
  output logic [SLAVES-1:0]    rsp_slave,
  output logic                 spi_enable,
  output logic                 spi_start_transaction,
  output logic                 spi_operation,
  output logic [SLAVES-1:0]    spi_slave,
  output logic [OUT_WIDTH-1:0] spi_outgoing_data,
  input  logic                 spi_end_of_transaction,
  input  logic [IN_WIDTH-1:0]  spi_incoming_data,
  output logic                 busy,
  output logic                 err_timeout
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = 1 + SLAVES + OUT_WIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_EOT, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] mem [CMD_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, timeout;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  // a pending read response blocks the next issue so it can never be overwritten
  assign pop = state == IDLE && !empty && !rsp_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_slave, cmd_data};
  always_ff @(posedge clk) begin
    if (!rst_n) {spi_operation, spi_slave, spi_outgoing_data} <= '0;
    else if (pop) {spi_operation, spi_slave, spi_outgoing_data} <= mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk) spi_enable <= rst_n;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
  assign timeout = state == WAIT_EOT && !spi_end_of_transaction && cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || state == ISSUE) cnt <= '0;
    else if (state == WAIT_EOT) cnt <= cnt + TW'(1);
  end
  always_ff @(posedge clk) err_timeout <= rst_n && timeout;
`else
  assign timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = pop ? ISSUE : IDLE;
      ISSUE:    state_nx = WAIT_EOT;
      WAIT_EOT: state_nx = (spi_end_of_transaction || timeout) ? GAP : WAIT_EOT;
      GAP:      state_nx = spi_end_of_transaction ? GAP : IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    spi_start_transaction = state == ISSUE || state == WAIT_EOT;
    busy = !empty || state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_slave <= '0;
    end else if (state == WAIT_EOT && spi_end_of_transaction && spi_operation) begin
      rsp_valid <= 1'b1;
      rsp_data  <= spi_incoming_data;
      rsp_slave <= spi_slave;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_quick_spi_cmd_sequencer.sv
// tb_quick_spi_cmd_sequencer: scoreboard bench with a behavioural quick_spi_hard model
module tb_quick_spi_cmd_sequencer;
  typedef struct packed {logic op; logic [1:0] slave; logic [15:0] data;} cmd_t;
  typedef struct packed {logic [7:0] data; logic [1:0] slave;} rsp_t;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_op = 0;
  logic [1:0] cmd_slave = 0;
  logic [15:0] cmd_data = 0;
  logic rsp_valid, rsp_ready = 0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_slave;
  logic spi_enable, spi_start_transaction, spi_operation;
  logic [1:0] spi_slave;
  logic [15:0] spi_outgoing_data;
  logic spi_end_of_transaction;
  logic [7:0] spi_incoming_data;
  logic busy, err_timeout;
  int n_tests = 0, n_fail = 0, cyc = 0, n_starts = 0, err_seen = 0;
  int rdy_prob = 100, forced = -1;
  bit stall = 0;
  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];

  quick_spi_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_slave(cmd_slave), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_slave(rsp_slave), .spi_enable(spi_enable),
    .spi_start_transaction(spi_start_transaction), .spi_operation(spi_operation),
    .spi_slave(spi_slave), .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    rsp_ready = $urandom_range(0, 99) < rdy_prob;
  end

  // quick_spi_hard stand-in: answers each start after a random latency, holds eot 1-3 cycles
  initial begin
    cmd_t cur;
    int lat, hold, last_start;
    last_start = -100;
    spi_end_of_transaction = 0;
    spi_incoming_data = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && spi_start_transaction) begin
        n_starts++;
        chk("start_gap", cyc - last_start >= 4, 1);
        last_start = cyc;
        chk("start_while_rsp", rsp_valid, 0);
        if (exp_cmd.size() == 0) begin
          chk("issue_unexpected", 1, 0);
          cur = '0;
        end else cur = exp_cmd.pop_front();
        chk("issue_cmd", {spi_operation, spi_slave, spi_outgoing_data}, cur);
        lat = $urandom_range(1, 6);
        repeat (lat) @(posedge clk);
        while (stall) @(posedge clk);
        #1;
        chk("start_held", spi_start_transaction, 1);
        chk("payload_stable", {spi_operation, spi_slave, spi_outgoing_data}, cur);
        spi_end_of_transaction = 1;
        spi_incoming_data = forced >= 0 ? 8'(forced) : 8'($urandom);
        if (cur.op) exp_rsp.push_back('{spi_incoming_data, cur.slave});
        hold = $urandom_range(1, 3);
        @(posedge clk); #1;
        chk("start_drop", spi_start_transaction, 0);
        chk("rsp_latency", rsp_valid, cur.op);
        repeat (hold - 1) @(posedge clk);
        #1;
        spi_end_of_transaction = 0;
        spi_incoming_data = 8'($urandom);
      end
    end
  end

  initial begin
    bit pend;
    rsp_t prev;
    pend = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_timeout) err_seen++;
        if (pend) begin
          chk("rsp_hold_valid", rsp_valid, 1);
          chk("rsp_hold_data", {rsp_data, rsp_slave}, prev);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
          else chk("rsp_data", {rsp_data, rsp_slave}, exp_rsp.pop_front());
        end
        pend = rsp_valid && !rsp_ready;
        prev = '{rsp_data, rsp_slave};
      end
    end
  end

  task automatic push_cmd(input logic op, input logic [1:0] sl, input logic [15:0] d);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_op = op; cmd_slave = sl; cmd_data = d;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        exp_cmd.push_back('{op, sl, d});
      end
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      done = exp_cmd.size() == 0 && exp_rsp.size() == 0 && !busy && !spi_start_transaction && !rsp_valid;
    end
    chk("drain", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp();
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("rsp_wait", seen, 1);
  endtask

  initial begin
    int s0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", spi_start_transaction, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_enable", spi_enable, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("enable", spi_enable, 1);

    push_cmd(0, 2'b01, {8'hCC, 8'h82});
    chk("start_pop_cycle", spi_start_transaction, 0);
    @(posedge clk); #1;
    chk("start_issue_cycle", spi_start_transaction, 1);
    chk("write_data", spi_outgoing_data, 16'hCC82);
    wait_drain();

    rdy_prob = 0;
    forced = 'h95;
    push_cmd(1, 2'b10, 16'h1234);
    wait_rsp();
    chk("read_data", rsp_data, 8'h95);
    chk("read_slave", rsp_slave, 2'b10);
    forced = -1;
    rdy_prob = 100;
    wait_drain();

    stall = 1;
    push_cmd(0, 2'b01, 16'h0001);
    push_cmd(1, 2'b10, 16'h0002);
    push_cmd(0, 2'b01, 16'h0003);
    push_cmd(1, 2'b10, 16'h0004);
    push_cmd(0, 2'b01, 16'h0005);
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    stall = 0;
    wait_drain();

    rdy_prob = 0;
    @(posedge clk); @(posedge clk); #1;
    s0 = n_starts;
    push_cmd(1, 2'b01, 16'hAAAA);
    push_cmd(1, 2'b10, 16'h5555);
    wait_rsp();
    repeat (20) @(posedge clk);
    #1;
    chk("second_held", n_starts, s0 + 1);
    chk("rsp_still_valid", rsp_valid, 1);
    rdy_prob = 100;
    wait_drain();
    chk("both_issued", n_starts, s0 + 2);

    rdy_prob = 60;
    for (int i = 0; i < 150; i++) begin
      push_cmd(1'($urandom), i % 7 == 0 ? 2'($urandom) : 2'(1 << $urandom_range(0, 1)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_prob = 100;
    wait_drain();
    chk("no_timeout", err_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
